// File: rtl/lu_pkg.sv
// Shared constants for the bit-serial logic-unit front end.
//   - LU opcodes presented on lu_select
//   - FSM state encoding used by lu_serial_sequencer
package lu_pkg;

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_NONE = 3'b111;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/lu_shreg.sv
// Right-shift register with parallel load and serial input at the MSB.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears to 0)
//   load, d     - parallel load (has priority over shift)
//   shift, sin  - shift right by one, sin enters at bit WIDTH-1
//   q           - register contents
module lu_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)      q <= '0;
    else if (load)  q <= d;
    else if (shift) q <= {sin, q[WIDTH-1:1]};
  end

endmodule

// File: rtl/lu_serial_sequencer.sv
// Bit-serial front end for the 1-bit logic unit. Takes a WIDTH-bit request
// (A, B, opcode, negate), presents one bit pair per cycle LSB first on lu_*,
// collects lu_z into the result MSB each cycle, and returns the word.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   in_valid/in_ready, in_a, in_b,
//   in_select, in_negate             - request handshake and operands
//   lu_a, lu_b, lu_select, lu_negate - drive to the LU (zero outside SHIFT)
//   lu_z                             - LU result bit, same cycle
//   out_valid/out_ready, out_result,
//   out_zero, out_nop                - result handshake and flags
//   busy                             - not IDLE
module lu_serial_sequencer
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_select,
  input  logic             in_negate,
  output logic             lu_a,
  output logic             lu_b,
  output logic [2:0]       lu_select,
  output logic             lu_negate,
  input  logic             lu_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_nop,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [2:0]       sel_q;
  logic             neg_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;

  logic accept, in_shift;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign in_shift = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      sel_q <= '0;
      neg_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= SHIFT;
          count <= '0;
          sel_q <= in_select;
          neg_q <= in_negate;
        end
        SHIFT: begin
          if (count == LAST) state <= DONE;
          else               count <= count + 1'b1;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operands drain LSB first; the result fills from the MSB so that after
  // WIDTH shifts the first LU bit has landed in bit 0.
  lu_shreg #(.WIDTH(WIDTH)) u_a (
    .clk(clk), .reset(reset), .load(accept), .d(in_a),
    .shift(in_shift), .sin(1'b0), .q(a_q)
  );

  lu_shreg #(.WIDTH(WIDTH)) u_b (
    .clk(clk), .reset(reset), .load(accept), .d(in_b),
    .shift(in_shift), .sin(1'b0), .q(b_q)
  );

  lu_shreg #(.WIDTH(WIDTH)) u_res (
    .clk(clk), .reset(reset), .load(accept), .d('0),
    .shift(in_shift), .sin(lu_z), .q(res_q)
  );

  assign lu_a      = in_shift & a_q[0];
  assign lu_b      = in_shift & b_q[0];
  assign lu_select = in_shift ? sel_q : 3'b000;
  assign lu_negate = in_shift & neg_q;

  assign out_valid  = (state == DONE);
  assign out_result = res_q;
  assign out_zero   = (res_q == '0);
  assign out_nop    = (sel_q == OP_NONE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_lu_serial_sequencer.sv
module tb_lu_serial_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic [2:0]   in_select;
  logic         in_negate;
  logic         lu_a, lu_b, lu_negate, lu_z;
  logic [2:0]   lu_select;
  logic         out_valid, out_ready;
  logic [W-1:0] out_result;
  logic         out_zero, out_nop, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lu_serial_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_select(in_select), .in_negate(in_negate),
    .lu_a(lu_a), .lu_b(lu_b), .lu_select(lu_select), .lu_negate(lu_negate),
    .lu_z(lu_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_nop(out_nop),
    .busy(busy)
  );

  // 1-bit logic unit
  logic la;
  always_comb begin
    la = lu_a ^ lu_negate;
    case (lu_select)
      3'b000:  lu_z = ~la;
      3'b001:  lu_z = la & lu_b;
      3'b010:  lu_z = ~(la & lu_b);
      3'b011:  lu_z = la | lu_b;
      3'b100:  lu_z = ~(la | lu_b);
      3'b101:  lu_z = la ^ lu_b;
      3'b110:  lu_z = ~(la ^ lu_b);
      default: lu_z = 1'b0;
    endcase
  end

  // Issue one request, scramble inputs after acceptance, wait for out_valid.
  // Leaves the result in DONE (not consumed). lat = edges after accept.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] sel, input logic neg,
                        output int lat);
    in_a = a; in_b = b; in_select = sel; in_negate = neg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_select = ~sel; in_negate = ~neg;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      fails++; $display("FAIL reset_ctrl: got ready/valid/busy=%b want 100", {in_ready, out_valid, busy});
    end
    tests++;
    if ({lu_a, lu_b, lu_select, lu_negate} !== 6'b0) begin
      fails++; $display("FAIL reset_lu: got %b want 000000", {lu_a, lu_b, lu_select, lu_negate});
    end
    tests++;
    if ({out_result, out_zero, out_nop} !== {8'h00, 1'b1, 1'b0}) begin
      fails++; $display("FAIL reset_out: got res=%h z=%b nop=%b want 00 1 0", out_result, out_zero, out_nop);
    end
  endtask

  task automatic test_and();
    int lat;
    run_op(8'hA5, 8'h0F, 3'b001, 1'b0, lat);
    tests++;
    if (lat !== 8) begin
      fails++; $display("FAIL and_latency: got %0d want 8", lat);
    end
    tests++;
    if ({out_result, out_zero} !== {8'h05, 1'b0}) begin
      fails++; $display("FAIL and_result: got %h z=%b want 05 z=0", out_result, out_zero);
    end
    consume();
    tests++;
    if ({busy, in_ready, out_valid} !== 3'b010) begin
      fails++; $display("FAIL and_idle: got busy/ready/valid=%b want 010", {busy, in_ready, out_valid});
    end
  endtask

  task automatic test_negate();
    int lat;
    run_op(8'h3C, 8'h00, 3'b000, 1'b1, lat);
    tests++;
    if (out_result !== 8'h3C || lat !== 8) begin
      fails++; $display("FAIL not_neg: got %h lat=%0d want 3c lat=8", out_result, lat);
    end
    consume();
    run_op(8'h3C, 8'hF0, 3'b101, 1'b1, lat);
    tests++;
    if (out_result !== 8'h33) begin
      fails++; $display("FAIL xor_neg: got %h want 33", out_result);
    end
    consume();
  endtask

  task automatic test_zero_nop();
    int lat;
    run_op(8'hFF, 8'h00, 3'b110, 1'b0, lat);
    tests++;
    if ({out_result, out_zero, out_nop} !== {8'h00, 1'b1, 1'b0}) begin
      fails++; $display("FAIL xnor_zero: got %h z=%b nop=%b want 00 1 0", out_result, out_zero, out_nop);
    end
    consume();
    run_op(8'hFF, 8'h00, 3'b111, 1'b0, lat);
    tests++;
    if ({out_result, out_zero, out_nop} !== {8'h00, 1'b1, 1'b1}) begin
      fails++; $display("FAIL none_nop: got %h z=%b nop=%b want 00 1 1", out_result, out_zero, out_nop);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    run_op(8'hC3, 8'h5A, 3'b011, 1'b0, lat);  // OR -> DB
    bad = 0;
    in_a = 8'h00; in_b = 8'h00; in_select = 3'b000; in_negate = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_result !== 8'hDB || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL bp_hold: %0d cycles unstable, res=%h want db held", bad, out_result);
    end
    consume();
    tests++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      fails++; $display("FAIL bp_release: got busy/valid/ready=%b want 001", {busy, out_valid, in_ready});
    end
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    in_a = 8'hFF; in_b = 8'hFF; in_select = 3'b001; in_negate = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;       // held through the 3rd SHIFT cycle's edge
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if ({in_ready, busy, out_valid, out_result} !== {3'b100, 8'h00}) begin
      fails++; $display("FAIL rst_abort: got ready/busy/valid=%b res=%h want 100 00",
                        {in_ready, busy, out_valid}, out_result);
    end
    tests++;
    if ({lu_a, lu_b, lu_select, lu_negate} !== 6'b0) begin
      fails++; $display("FAIL rst_lu: got %b want 000000", {lu_a, lu_b, lu_select, lu_negate});
    end
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL rst_no_valid: out_valid high %0d cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(8'hF0, 8'h0F, 3'b010, 1'b0, lat);  // NAND -> FF
    tests++;
    if (out_result !== 8'hFF) begin
      fails++; $display("FAIL b2b_first: got %h want ff", out_result);
    end
    consume();
    run_op(8'h81, 8'h01, 3'b100, 1'b0, lat);  // NOR -> 7E
    tests++;
    if (out_result !== 8'h7E || lat !== 8) begin
      fails++; $display("FAIL b2b_second: got %h lat=%0d want 7e lat=8", out_result, lat);
    end
    consume();
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_select = '0; in_negate = 1'b0;
    reset = 1'b1;
    test_reset();
    test_and();
    test_negate();
    test_zero_nop();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
